mux_n_1_rr: RTL and testbench
=============================

// Module: mux_n_1_rr
// PURPOSE
//  Parametrised N:1 data selector; successor to the fixed 4:1 combinational mux.
//  Adds a registered output stage with valid/ready handshake and two select modes:
//  external select, or round-robin arbitration across requesting channels.
//  Sits between N producer channels and a single consumer.
// PARAMETERS
//  N     4  number of input channels (>=2)
//  W     4  data width per channel, bits
//  MODE  1  0 = external select via sel; 1 = round-robin arbitration
//  SW    derived localparam = $clog2(N); width of sel, out_ch and rr pointer
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  in_data    in   N*W  channel i occupies bits [i*W +: W]
//  in_valid   in   N    channel i offers a word
//  in_ready   out  N    channel i word accepted this cycle (combinational)
//  sel        in   SW   channel select, used only when MODE=0
//  out_data   out  W    registered selected word
//  out_ch     out  SW   index of channel that supplied out_data
//  out_valid  out  1    out_data/out_ch hold a valid word
//  out_ready  in   1    consumer accepts word when out_valid && out_ready
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//    Any held word is dropped. in_ready=0 while rst=1.
//  - Output stage, 2 states: EMPTY (out_valid=0), FULL (out_valid=1).
//  - load = !out_valid || out_ready.
//  - Grant (combinational, one-hot or zero):
//    MODE=0: grant[sel] = in_valid[sel]; sel >= N grants nothing.
//    MODE=1: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping N-1 -> 0.
//  - in_ready[i] = load && grant[i] && !rst. At most one bit set.
//  - On posedge with load and a grant on channel g:
//    out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//    In MODE=1, rr_ptr <= (g==N-1) ? 0 : g+1.
//  - On posedge with load and no grant: out_valid <= 0. out_data and out_ch hold.
//  - FULL && !out_ready: out_data, out_ch, out_valid hold stable; in_ready = 0.
//  - Latency: an accepted word appears on out_* one cycle after acceptance.
//    Full throughput of 1 word/cycle while out_ready=1.
//  - Simultaneous consume and accept (FULL && out_ready && grant):
//    the new word replaces the old one, out_valid stays 1.
//  - sel or in_valid changes while FULL && stalled do not affect the held word.
//  - rr_ptr advances only on an accepted grant; it never moves on idle cycles.
//  - Producers may drop in_valid without handshake; no word is lost or duplicated.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all in_valid=1
//    -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//  2 MODE=0 exhaustive, N=4, W=4: sweep x over 0..15 on every channel, every sel value, out_ready=1
//    -> out_data = in_data[sel] one cycle later; out_ch = sel.
//  3 MODE=1 fairness: in_valid=4'b1111, out_ready=1
//    -> out_ch sequence 0,1,2,3,0,1 and exactly one in_ready bit per cycle.
//  4 MODE=1 sparse requests: in_valid=4'b1010, rr_ptr=0 -> out_ch 1,3,1,3.
//    Then in_valid=4'b0001 -> out_ch 0.
//  5 Backpressure: out_ready=0 for 5 cycles after first word 4'hA
//    -> out_data=4'hA held, in_ready=0. Release out_ready -> next word follows, none lost.
//  6 Reset mid-stream: assert rst while FULL with out_ready=0
//    -> next cycle out_valid=0, rr_ptr=0. First grant after release is the lowest valid channel.

Source files
------------

// File: rtl/mux_n_1_rr.sv
// rtl/mux_n_1_rr.sv - N:1 selector with registered valid/ready output stage
// Select by external sel (MODE=0) or round-robin over requesting channels (MODE=1).
module mux_n_1_rr #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int SW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load;
    logic [N-1:0]  hi_mask;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  sel_grant;
    logic [N-1:0]  grant;
    logic [SW-1:0] g_idx;
    logic [W-1:0]  g_data;

    always_comb begin
        load      = (state_q == EMPTY) || out_ready;
        hi_mask   = '0;
        sel_grant = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i]   = (SW'(i) >= rr_ptr_q);
            sel_grant[i] = in_valid[i] && (sel == SW'(i));
        end
        // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
        req_hi = in_valid & hi_mask;
        if (|req_hi) begin
            rr_grant = req_hi & (~req_hi + N'(1));
        end else begin
            rr_grant = in_valid & (~in_valid + N'(1));
        end
        grant = (MODE == 1) ? rr_grant : sel_grant;

        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                g_idx  = SW'(i);
                g_data = in_data[i*W +: W];
            end
        end

        in_ready = (load && !rst) ? grant : '0;

        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            if (|grant) begin
                state_d    = FULL;
                out_data_d = g_data;
                out_ch_d   = g_idx;
                if (MODE == 1) begin
                    rr_ptr_d = (g_idx == SW'(N - 1)) ? '0 : g_idx + SW'(1);
                end
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// tb/tb_mux_n_1_rr.sv - directed bench for mux_n_1_rr in both select modes
module tb_mux_n_1_rr;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  s_in_ready, r_in_ready;
    logic [3:0]  s_out_data, r_out_data;
    logic [1:0]  s_out_ch, r_out_ch;
    logic        s_out_valid, r_out_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_n_1_rr #(.N(4), .W(4), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_in_ready), .sel(sel), .out_data(s_out_data),
        .out_ch(s_out_ch), .out_valid(s_out_valid), .out_ready(out_ready)
    );

    mux_n_1_rr #(.N(4), .W(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r_in_ready), .sel(sel), .out_data(r_out_data),
        .out_ch(r_out_ch), .out_valid(r_out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack(input logic [3:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] x4;
        int exp_ch;

        // Reset with every channel requesting
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = pack(4'h1, 4'h2, 4'h3, 4'h4);
        sel       = 2'd2;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_data", s_out_data, 0);
        chk("rst_s_ch", s_out_ch, 0);
        chk("rst_s_ready", s_in_ready, 0);
        chk("rst_r_valid", r_out_valid, 0);
        chk("rst_r_data", r_out_data, 0);
        chk("rst_r_ch", r_out_ch, 0);
        chk("rst_r_ready", r_in_ready, 0);
        rst = 1'b0;

        // External select sweep: channel i carries x+i
        for (int x = 0; x < 16; x++) begin
            for (int s = 0; s < 4; s++) begin
                x4      = 4'(x);
                in_data = pack(x4, x4 + 4'd1, x4 + 4'd2, x4 + 4'd3);
                sel     = 2'(s);
                #1;
                chk("sel_in_ready", s_in_ready, 32'd1 << s);
                step();
                chk("sel_data", s_out_data, 32'((x + s) % 16));
                chk("sel_ch", s_out_ch, s);
                chk("sel_valid", s_out_valid, 1);
            end
        end
        // Selected channel idle: nothing granted, output drains, word holds
        in_valid = 4'b1110;
        sel      = 2'd0;
        #1;
        chk("sel_idle_ready", s_in_ready, 0);
        step();
        chk("sel_idle_valid", s_out_valid, 0);
        chk("sel_idle_data", s_out_data, 4'h2);
        chk("sel_idle_ch", s_out_ch, 3);

        // Round-robin fairness with all requesting
        do_reset();
        in_valid = 4'b1111;
        in_data  = pack(4'h1, 4'h2, 4'h3, 4'h4);
        for (int k = 0; k < 6; k++) begin
            exp_ch = k % 4;
            #1;
            chk("rr_fair_ready", r_in_ready, 32'd1 << exp_ch);
            step();
            chk("rr_fair_ch", r_out_ch, exp_ch);
            chk("rr_fair_data", r_out_data, exp_ch + 1);
        end

        // Sparse requests
        do_reset();
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_sparse_ch", r_out_ch, (k % 2 == 0) ? 1 : 3);
            chk("rr_sparse_valid", r_out_valid, 1);
        end
        in_valid = 4'b0001;
        step();
        chk("rr_single_ch", r_out_ch, 0);
        // Idle cycle leaves the pointer at 1
        in_valid = 4'b0000;
        step();
        chk("rr_idle_valid", r_out_valid, 0);
        chk("rr_idle_ch", r_out_ch, 0);
        in_valid = 4'b1111;
        step();
        chk("rr_after_idle_ch", r_out_ch, 1);

        // Backpressure: hold 4'hA for 5 stalled cycles
        do_reset();
        in_valid = 4'b0001;
        in_data  = pack(4'hA, 4'hB, 4'hC, 4'hD);
        step();
        chk("bp_first_data", r_out_data, 4'hA);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        in_data   = pack(4'h5, 4'hB, 4'hC, 4'hD);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", r_in_ready, 0);
            step();
            chk("bp_hold_data", r_out_data, 4'hA);
            chk("bp_hold_valid", r_out_valid, 1);
            chk("bp_hold_ch", r_out_ch, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", r_in_ready, 4'b0010);
        step();
        chk("bp_next_data", r_out_data, 4'hB);
        chk("bp_next_ch", r_out_ch, 1);
        in_valid = 4'b0000;
        step();
        chk("bp_drain_valid", r_out_valid, 0);

        // Reset while full and stalled clears state and pointer
        in_valid = 4'b0100;
        step();
        chk("mid_ch", r_out_ch, 2);
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", r_in_ready, 0);
        step();
        chk("mid_rst_valid", r_out_valid, 0);
        rst       = 1'b0;
        in_valid  = 4'b1110;
        out_ready = 1'b1;
        #1;
        chk("mid_first_ready", r_in_ready, 4'b0010);
        step();
        chk("mid_first_ch", r_out_ch, 1);
        chk("mid_first_valid", r_out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
